// File: rtl/grass_scroll_ctrl.sv
// Per-frame scroll offset, blade sway and wind-gust sequencer for the grass layer.
// Optional macro GRASS_SCROLL_DIR_EN adds a dir input that selects leftward scrolling.
module grass_scroll_ctrl #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned CALM_MIN    = 60,
    parameter int unsigned GUST_FRAMES = 32,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       enable,
    input  logic [1:0] speed,
    input  logic       gust_req,
`ifdef GRASS_SCROLL_DIR_EN
    input  logic       dir,
`endif
    output logic [9:0] scroll_x,
    output logic [2:0] sway,
    output logic       gust_active,
    output logic [1:0] boost
);

    localparam int unsigned CALM_W = $clog2(CALM_MIN + 1);
    localparam int unsigned HOLD_W = $clog2(GUST_FRAMES + 1);
    localparam logic [CALM_W-1:0] CALM_MAX  = CALM_W'(CALM_MIN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(GUST_FRAMES);
    localparam logic [10:0]       SCREEN_WX = 11'(SCREEN_W);

    typedef enum logic [1:0] {
        ST_CALM  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DECAY = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [CALM_W-1:0]   r_calm, w_calm_next, w_calm_inc;
    logic [HOLD_W-1:0]   r_hold, w_hold_next, w_hold_inc;
    logic [1:0]          r_boost, w_boost_next;
    logic                r_gust, w_gust_next;
    logic                r_pending, w_pending_next;
    logic [7:0]          r_lfsr, w_lfsr_next;
    logic [9:0]          r_scroll, w_scroll_next;
    logic [2:0]          r_sway, w_sway_next;
    logic                r_sway_up, w_sway_up_next;
    logic [1:0]          r_sway_div, w_sway_div_next;
    logic                w_update, w_dir_left, w_sway_step, w_gust_start;
    logic [10:0]         w_step, w_sum, w_diff;

    assign w_update   = frame_start & enable;
    assign w_calm_inc = (r_calm >= CALM_MAX) ? CALM_MAX : r_calm + CALM_W'(1);
    assign w_hold_inc = r_hold + HOLD_W'(1);
    assign w_gust_start = (r_state == ST_CALM) && (w_state_next == ST_RAMP);

`ifdef GRASS_SCROLL_DIR_EN
    assign w_dir_left = dir;
`else
    assign w_dir_left = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CALM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic, evaluated only on updating frames
    always_comb begin
        w_state_next = r_state;
        if (w_update) begin
            case (r_state)
                ST_CALM: begin
                    if (r_pending || gust_req ||
                        ((w_calm_inc >= CALM_MAX) && (r_lfsr[2:0] == 3'd0))) begin
                        w_state_next = ST_RAMP;
                    end else begin
                        w_state_next = ST_CALM;
                    end
                end
                ST_RAMP:  w_state_next = (r_boost == 2'd2) ? ST_HOLD : ST_RAMP;
                ST_HOLD:  w_state_next = (w_hold_inc == HOLD_LAST) ? ST_DECAY : ST_HOLD;
                ST_DECAY: w_state_next = (r_boost == 2'd1) ? ST_CALM : ST_DECAY;
                default:  w_state_next = ST_CALM;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Gust counters, boost and pending request
    always_comb begin
        w_calm_next  = r_calm;
        w_hold_next  = r_hold;
        w_boost_next = r_boost;
        if (w_update) begin
            case (r_state)
                ST_CALM: begin
                    w_calm_next  = w_calm_inc;
                    w_boost_next = w_gust_start ? 2'd1 : 2'd0;
                end
                ST_RAMP: begin
                    w_boost_next = r_boost + 2'd1;
                    w_hold_next  = {HOLD_W{1'b0}};
                end
                ST_HOLD:  w_hold_next = w_hold_inc;
                ST_DECAY: begin
                    w_boost_next = r_boost - 2'd1;
                    w_calm_next  = {CALM_W{1'b0}};
                end
                default: begin
                    w_boost_next = 2'd0;
                    w_calm_next  = {CALM_W{1'b0}};
                end
            endcase
        end else begin
            w_boost_next = r_boost;
        end
        // A request is only remembered while calm; it is used up by the gust it starts.
        if (w_update && w_gust_start) begin
            w_pending_next = 1'b0;
        end else if (gust_req && (r_state == ST_CALM)) begin
            w_pending_next = 1'b1;
        end else begin
            w_pending_next = r_pending;
        end
        w_gust_next = (w_state_next != ST_CALM);
    end

    // Scroll, sway and LFSR next values
    always_comb begin
        w_step = 11'(speed) + 11'(r_boost);
        w_sum  = {1'b0, r_scroll} + w_step;
        w_diff = {1'b0, r_scroll} + SCREEN_WX - w_step;
        w_scroll_next   = r_scroll;
        w_sway_next     = r_sway;
        w_sway_up_next  = r_sway_up;
        w_sway_div_next = r_sway_div;
        w_lfsr_next     = r_lfsr;
        w_sway_step     = (r_state != ST_CALM) || (r_sway_div == 2'd3);
        if (w_update) begin
            if (w_dir_left) begin
                w_scroll_next = (w_diff >= SCREEN_WX) ? 10'(w_diff - SCREEN_WX) : w_diff[9:0];
            end else begin
                w_scroll_next = (w_sum >= SCREEN_WX) ? 10'(w_sum - SCREEN_WX) : w_sum[9:0];
            end
            w_sway_div_next = (r_state == ST_CALM) ? r_sway_div + 2'd1 : 2'd0;
            if (w_sway_step && r_sway_up) begin
                w_sway_next    = r_sway + 3'd1;
                w_sway_up_next = (r_sway != 3'd6);
            end else if (w_sway_step) begin
                w_sway_next    = r_sway - 3'd1;
                w_sway_up_next = (r_sway == 3'd1);
            end else begin
                w_sway_next    = r_sway;
            end
            w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end else begin
            w_lfsr_next = r_lfsr;
        end
    end

    // Frame-rate datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_calm     <= {CALM_W{1'b0}};
            r_hold     <= {HOLD_W{1'b0}};
            r_boost    <= 2'd0;
            r_gust     <= 1'b0;
            r_pending  <= 1'b0;
            r_lfsr     <= LFSR_SEED;
            r_scroll   <= 10'd0;
            r_sway     <= 3'd0;
            r_sway_up  <= 1'b1;
            r_sway_div <= 2'd0;
        end else begin
            r_calm     <= w_calm_next;
            r_hold     <= w_hold_next;
            r_boost    <= w_boost_next;
            r_gust     <= w_gust_next;
            r_pending  <= w_pending_next;
            r_lfsr     <= w_lfsr_next;
            r_scroll   <= w_scroll_next;
            r_sway     <= w_sway_next;
            r_sway_up  <= w_sway_up_next;
            r_sway_div <= w_sway_div_next;
        end
    end

    assign scroll_x    = r_scroll;
    assign sway        = r_sway;
    assign gust_active = r_gust;
    assign boost       = r_boost;

endmodule

// File: tb/tb_grass_scroll_ctrl.sv
// Self-checking bench for grass_scroll_ctrl against a frame-level behavioural model.
module tb_grass_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] speed = 2'd0;
    logic       gust_req = 1'b0;
    logic       dir = 1'b0;
    logic [9:0] scroll_x;
    logic [2:0] sway;
    logic       gust_active;
    logic [1:0] boost;

    int errors = 0;
    int checks = 0;

    grass_scroll_ctrl dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
        .speed(speed), .gust_req(gust_req),
`ifdef GRASS_SCROLL_DIR_EN
        .dir(dir),
`endif
        .scroll_x(scroll_x), .sway(sway), .gust_active(gust_active), .boost(boost)
    );

    always #5 clk = ~clk;

    // Model: m_g counts frames since the gust began (0 = calm); m_p is a 14-step sway phase.
    int         m_scroll, m_p, m_div, m_g, m_calm, m_pend;
    logic [7:0] m_lfsr;

    function automatic int bo(input int g);
        if (g == 0) return 0;
        if (g <= 3) return g;
        if (g <= 35) return 3;
        return 38 - g;
    endfunction

    function automatic int e_sway();
        return (m_p <= 7) ? m_p : 14 - m_p;
    endfunction

    task automatic m_reset();
        m_scroll = 0; m_p = 0; m_div = 0; m_g = 0; m_calm = 0; m_pend = 0; m_lfsr = 8'hA5;
    endtask

    task automatic m_frame(input bit req);
        int  n;
        bit  calm_now;
        n = int'(speed) + bo(m_g);
        if (dir) m_scroll = (m_scroll - n + 640) % 640;
        else     m_scroll = (m_scroll + n) % 640;
        calm_now = (m_g == 0);
        if (calm_now) begin
            if (m_div == 3) m_p = (m_p + 1) % 14;
            m_div = (m_div + 1) % 4;
            m_calm = (m_calm + 1 > 60) ? 60 : m_calm + 1;
            if (m_pend != 0 || req || (m_calm >= 60 && m_lfsr[2:0] == 3'd0)) begin
                m_g = 1;
                m_pend = 0;
            end
        end else begin
            m_p = (m_p + 1) % 14;
            m_div = 0;
            m_g = m_g + 1;
            if (m_g == 38) begin
                m_g = 0;
                m_calm = 0;
            end
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    endtask

    task automatic tick(input bit fs, input bit req);
        frame_start = fs;
        gust_req = req;
        @(posedge clk);
        if (rst_n) begin
            if (fs && enable) m_frame(req);
            else if (req && m_g == 0) m_pend = 1;
        end
        #1;
        frame_start = 1'b0;
        gust_req = 1'b0;
    endtask

    task automatic frame();
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        m_reset();
    endtask

    task automatic test_reset();
        enable = 1'b1; speed = 2'd2; dir = 1'b0;
        do_reset();
        checks++; if (scroll_x !== 10'd0 || sway !== 3'd0 || gust_active !== 1'b0 || boost !== 2'd0) begin
            errors++; $display("FAIL reset_state: got scroll=%0d sway=%0d gust=%0b boost=%0d, want all 0",
                               scroll_x, sway, gust_active, boost);
        end
        for (int i = 1; i <= 5; i++) begin
            frame();
            if (i == 3) begin
                checks++; if (scroll_x !== 10'd6 || sway !== 3'd0) begin
                    errors++; $display("FAIL frame3: got scroll=%0d sway=%0d, want 6 0", scroll_x, sway);
                end
            end
        end
        tick(1'b0, 1'b0);
        checks++; if (scroll_x !== 10'd10 || sway !== 3'd1 || gust_active !== 1'b0 || boost !== 2'd0) begin
            errors++; $display("FAIL five_frames: got scroll=%0d sway=%0d gust=%0b boost=%0d, want 10 1 0 0",
                               scroll_x, sway, gust_active, boost);
        end
    endtask

    task automatic test_wrap();
        int rem, sp, exp_s;
        enable = 1'b1; dir = 1'b0;
        do_reset();
        for (int k = 0; k < 3000 && m_scroll != 638; k++) begin
            rem = 638 - m_scroll;
            if (rem < 0) rem = rem + 640;
            sp = rem - bo(m_g);
            if (sp < 0) sp = 0;
            if (sp > 3) sp = 3;
            speed = 2'(sp);
            frame();
        end
        checks++; if (scroll_x !== 10'd638) begin
            errors++; $display("FAIL wrap_setup: got scroll=%0d, want 638", scroll_x);
        end
        speed = 2'd3;
        exp_s = (638 + 3 + bo(m_g)) % 640;
        frame();
        checks++; if (int'(scroll_x) !== exp_s) begin
            errors++; $display("FAIL wrap_step: got scroll=%0d, want %0d", scroll_x, exp_s);
        end
    endtask

    task automatic test_gust();
        int exp_b[3] = '{2, 1, 0};
        enable = 1'b1; speed = 2'd0; dir = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) frame();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            frame();
            checks++; if (int'(boost) !== i || gust_active !== 1'b1) begin
                errors++; $display("FAIL ramp%0d: got boost=%0d gust=%0b, want %0d 1", i, boost, gust_active, i);
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (i == 10) tick(1'b0, 1'b1);
            frame();
            checks++; if (boost !== 2'd3 || gust_active !== 1'b1 || int'(sway) !== e_sway()) begin
                errors++; $display("FAIL hold%0d: got boost=%0d gust=%0b sway=%0d, want 3 1 %0d",
                                   i, boost, gust_active, sway, e_sway());
            end
        end
        for (int i = 0; i < 3; i++) begin
            frame();
            checks++; if (int'(boost) !== exp_b[i] || gust_active !== (i < 2)) begin
                errors++; $display("FAIL decay%0d: got boost=%0d gust=%0b, want %0d %0b",
                                   i, boost, gust_active, exp_b[i], i < 2);
            end
        end
        for (int i = 0; i < 3; i++) frame();
        checks++; if (gust_active !== 1'b0 || boost !== 2'd0) begin
            errors++; $display("FAIL hold_req_dropped: got gust=%0b boost=%0d, want 0 0", gust_active, boost);
        end
        // Asynchronous reset in the middle of a gust
        tick(1'b0, 1'b1);
        frame(); frame();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (scroll_x !== 10'd0 || sway !== 3'd0 || gust_active !== 1'b0 || boost !== 2'd0) begin
            errors++; $display("FAIL async_reset: got scroll=%0d sway=%0d gust=%0b boost=%0d, want all 0",
                               scroll_x, sway, gust_active, boost);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_reset();
        speed = 2'd2;
        for (int i = 0; i < 5; i++) frame();
        checks++; if (scroll_x !== 10'd10 || sway !== 3'd1 || gust_active !== 1'b0) begin
            errors++; $display("FAIL after_reset: got scroll=%0d sway=%0d gust=%0b, want 10 1 0",
                               scroll_x, sway, gust_active);
        end
    endtask

    task automatic test_enable();
        enable = 1'b1; speed = 2'd1; dir = 1'b0;
        do_reset();
        frame(); frame();
        enable = 1'b0; speed = 2'd3;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) tick(1'b0, 1'b1);
            frame();
            checks++; if (scroll_x !== 10'd2 || sway !== 3'd0 || gust_active !== 1'b0 || boost !== 2'd0) begin
                errors++; $display("FAIL frozen%0d: got scroll=%0d sway=%0d gust=%0b boost=%0d, want 2 0 0 0",
                                   i, scroll_x, sway, gust_active, boost);
            end
        end
        enable = 1'b1;
        frame();
        checks++; if (scroll_x !== 10'd5 || gust_active !== 1'b1 || boost !== 2'd1) begin
            errors++; $display("FAIL enable_gust: got scroll=%0d gust=%0b boost=%0d, want 5 1 1",
                               scroll_x, gust_active, boost);
        end
    endtask

    task automatic test_lfsr_gust();
        logic [7:0] l;
        int pred, first;
        enable = 1'b1; speed = 2'd1; dir = 1'b0;
        do_reset();
        l = 8'hA5; pred = 0; first = 0;
        for (int f = 1; f < 1000 && pred == 0; f++) begin
            if (f >= 60 && l[2:0] == 3'd0) pred = f;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        for (int f = 1; f <= 600 && first == 0; f++) begin
            frame();
            if (gust_active === 1'b1) first = f;
        end
        checks++; if (first !== pred || first < 60) begin
            errors++; $display("FAIL lfsr_gust_frame: got %0d, want %0d", first, pred);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        enable = 1'b1; dir = 1'b0;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            speed = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 99) < 85);
`ifdef GRASS_SCROLL_DIR_EN
            dir = 1'($urandom_range(0, 1));
`endif
            if ($urandom_range(0, 99) < 3) tick(1'b0, 1'b1);
            tick(1'b1, ($urandom_range(0, 99) < 2));
            if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0);
            checks++; if (int'(scroll_x) !== m_scroll || int'(sway) !== e_sway() ||
                          int'(boost) !== bo(m_g) || gust_active !== (m_g != 0) || scroll_x >= 10'd640) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random%0d: got scroll=%0d sway=%0d boost=%0d gust=%0b, want %0d %0d %0d %0b",
                                       i, scroll_x, sway, boost, gust_active, m_scroll, e_sway(), bo(m_g), m_g != 0);
            end
        end
        dir = 1'b0;
    endtask

`ifdef GRASS_SCROLL_DIR_EN
    task automatic test_dir();
        enable = 1'b1; dir = 1'b0;
        do_reset();
        tick(1'b0, 1'b1);
        speed = 2'd0; frame();
        speed = 2'd1; frame();
        checks++; if (scroll_x !== 10'd2 || boost !== 2'd2) begin
            errors++; $display("FAIL dir_setup: got scroll=%0d boost=%0d, want 2 2", scroll_x, boost);
        end
        speed = 2'd3; dir = 1'b1; frame();
        checks++; if (scroll_x !== 10'd637) begin
            errors++; $display("FAIL dir_left: got scroll=%0d, want 637", scroll_x);
        end
        dir = 1'b0;
    endtask
`endif

    initial begin
        m_reset();
        @(posedge clk); #1;
        test_reset();
        test_wrap();
        test_gust();
        test_enable();
        test_lfsr_gust();
        test_random();
`ifdef GRASS_SCROLL_DIR_EN
        test_dir();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
